regfile_sb: RTL and testbench

//  Parametrised general-purpose register file with one write port, two async read ports,
//  per-register busy scoreboard, registered busy count and synchronous clear.

---
 rtl/regfile_sb.sv | 123 ++++++++++++
 tb/tb_regfile_sb.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - register file with one write port, two async reads and a busy scoreboard
// Optional write-to-read forwarding is enabled by defining REGFILE_SB_BYPASS_EN.
module regfile_sb #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter bit R0_ZERO  = 1'b0,
    parameter int CNT_W    = $clog2(NUM_REGS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    input  logic [ADDR_W-1:0] rd0_addr,
    input  logic [ADDR_W-1:0] rd1_addr,
    output logic [DATA_W-1:0] rd0_data,
    output logic [DATA_W-1:0] rd1_data,
    output logic              rd0_busy,
    output logic              rd1_busy,
    output logic              rsv_err,
    output logic [CNT_W-1:0]  busy_cnt
);

    localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(NUM_REGS);

    logic [DATA_W-1:0]   mem [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_nxt;
    logic [CNT_W-1:0]    cnt_nxt;
    logic                rsv_hit;
    logic                wr_ok;
    logic                rsv_ok;

    // An address is writable/reservable only if it exists and is not a hardwired r0
    assign wr_ok  = wr_en  && ({1'b0, wr_addr}  < LIMIT) && !(R0_ZERO && wr_addr  == '0);
    assign rsv_ok = rsv_en && ({1'b0, rsv_addr} < LIMIT) && !(R0_ZERO && rsv_addr == '0);

    always_comb begin
        busy_nxt = busy;
        rsv_hit  = 1'b0;
        cnt_nxt  = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_ok && wr_addr == ADDR_W'(i)) begin
                busy_nxt[i] = 1'b0;
            end
            // Reserve applied after the write so the new producer wins on a collision
            if (rsv_ok && rsv_addr == ADDR_W'(i)) begin
                busy_nxt[i] = 1'b1;
                rsv_hit     = busy[i];
            end
        end
        for (int i = 0; i < NUM_REGS; i++) begin
            cnt_nxt = cnt_nxt + CNT_W'(busy_nxt[i]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem[i] <= '0;
            end
            busy     <= '0;
            rsv_err  <= 1'b0;
            busy_cnt <= '0;
        end else if (clr) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem[i] <= '0;
            end
            busy     <= '0;
            rsv_err  <= 1'b0;
            busy_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_ok && wr_addr == ADDR_W'(i)) begin
                    mem[i] <= wr_data;
                end
            end
            busy     <= busy_nxt;
            rsv_err  <= rsv_hit;
            busy_cnt <= cnt_nxt;
        end
    end

    always_comb begin
        rd0_data = '0;
        rd0_busy = 1'b0;
        rd1_data = '0;
        rd1_busy = 1'b0;
        // Out-of-range addresses match no entry and read as zero, not busy
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd0_addr == ADDR_W'(i)) begin
                rd0_data = mem[i];
                rd0_busy = busy[i];
            end
            if (rd1_addr == ADDR_W'(i)) begin
                rd1_data = mem[i];
                rd1_busy = busy[i];
            end
        end
`ifdef REGFILE_SB_BYPASS_EN
        if (wr_ok && wr_addr == rd0_addr) begin
            rd0_data = wr_data;
            rd0_busy = rsv_ok && (rsv_addr == rd0_addr);
        end
        if (wr_ok && wr_addr == rd1_addr) begin
            rd1_data = wr_data;
            rd1_busy = rsv_ok && (rsv_addr == rd1_addr);
        end
`else
`endif
        if (!rst) begin
            rd0_data = '0;
            rd0_busy = 1'b0;
            rd1_data = '0;
            rd1_busy = 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - scoreboard bench for regfile_sb (default and R0_ZERO/6-entry builds)
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    logic        clr, wr_en, rsv_en;
    logic [2:0]  wr_addr, rsv_addr, rd0_addr, rd1_addr;
    logic [15:0] wr_data, rd0_data, rd1_data;
    logic        rd0_busy, rd1_busy, rsv_err;
    logic [3:0]  busy_cnt;

    logic        b_clr, b_wr_en, b_rsv_en;
    logic [2:0]  b_wr_addr, b_rsv_addr, b_rd0_addr, b_rd1_addr;
    logic [15:0] b_wr_data, b_rd0_data, b_rd1_data;
    logic        b_rd0_busy, b_rd1_busy, b_rsv_err;
    logic [2:0]  b_busy_cnt;

    regfile_sb dut_a (
        .clk(clk), .rst(rst), .clr(clr),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .rd0_addr(rd0_addr), .rd1_addr(rd1_addr),
        .rd0_data(rd0_data), .rd1_data(rd1_data),
        .rd0_busy(rd0_busy), .rd1_busy(rd1_busy),
        .rsv_err(rsv_err), .busy_cnt(busy_cnt)
    );

    regfile_sb #(.NUM_REGS(6), .R0_ZERO(1'b1)) dut_b (
        .clk(clk), .rst(rst), .clr(b_clr),
        .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .rsv_en(b_rsv_en), .rsv_addr(b_rsv_addr),
        .rd0_addr(b_rd0_addr), .rd1_addr(b_rd1_addr),
        .rd0_data(b_rd0_data), .rd1_data(b_rd1_data),
        .rd0_busy(b_rd0_busy), .rd1_busy(b_rd1_busy),
        .rsv_err(b_rsv_err), .busy_cnt(b_busy_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        int          kind;
        logic [31:0] exp;
    } exp_t;

    exp_t q[$];
    exp_t e;
    logic [31:0] act;

    localparam int K_D0 = 0, K_B0 = 1, K_D1 = 2, K_B1 = 3, K_ERR = 4, K_CNT = 5;
    localparam int K_BD0 = 6, K_BB0 = 7, K_BERR = 8, K_BCNT = 9;

    function automatic logic [31:0] actual(input int k);
        case (k)
            K_D0:    return {16'b0, rd0_data};
            K_B0:    return {31'b0, rd0_busy};
            K_D1:    return {16'b0, rd1_data};
            K_B1:    return {31'b0, rd1_busy};
            K_ERR:   return {31'b0, rsv_err};
            K_CNT:   return {28'b0, busy_cnt};
            K_BD0:   return {16'b0, b_rd0_data};
            K_BB0:   return {31'b0, b_rd0_busy};
            K_BERR:  return {31'b0, b_rsv_err};
            default: return {29'b0, b_busy_cnt};
        endcase
    endfunction

    function automatic string kname(input int k);
        case (k)
            K_D0:    return "rd0_data";
            K_B0:    return "rd0_busy";
            K_D1:    return "rd1_data";
            K_B1:    return "rd1_busy";
            K_ERR:   return "rsv_err";
            K_CNT:   return "busy_cnt";
            K_BD0:   return "b_rd0_data";
            K_BB0:   return "b_rd0_busy";
            K_BERR:  return "b_rsv_err";
            default: return "b_busy_cnt";
        endcase
    endfunction

    // Monitor: compares every expectation queued for the current cycle
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            act = actual(e.kind);
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL %s cycle %0d actual=%0h required=%0h", kname(e.kind), cyc, act, e.exp);
            end
        end
    end

    task automatic expect_now(input int k, input logic [31:0] v);
        exp_t x;
        x.cyc  = cyc;
        x.kind = k;
        x.exp  = v;
        q.push_back(x);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clr = 0; wr_en = 0; rsv_en = 0; wr_addr = 0; rsv_addr = 0; wr_data = 0;
        rd0_addr = 0; rd1_addr = 0;
        b_clr = 0; b_wr_en = 0; b_rsv_en = 0; b_wr_addr = 0; b_rsv_addr = 0; b_wr_data = 0;
        b_rd0_addr = 0; b_rd1_addr = 0;
        tick(); tick();
        expect_now(K_D0, 0); expect_now(K_B0, 0); expect_now(K_ERR, 0); expect_now(K_CNT, 0);
        tick();
        rst = 1;
        tick();

        // Write r3, read it back next cycle
        wr_en = 1; wr_addr = 3; wr_data = 16'h1234;
        tick();
        wr_en = 0; rd0_addr = 3;
        expect_now(K_D0, 32'h1234); expect_now(K_B0, 0);
        tick();

        // Reserve r5, then writeback clears it
        rsv_en = 1; rsv_addr = 5;
        tick();
        rsv_en = 0; rd1_addr = 5;
        expect_now(K_B1, 1); expect_now(K_CNT, 1);
        wr_en = 1; wr_addr = 5; wr_data = 16'hBEEF;
        tick();
        wr_en = 0;
        expect_now(K_B1, 0); expect_now(K_CNT, 0); expect_now(K_D1, 32'hBEEF); expect_now(K_ERR, 0);

        // Double reserve of r2
        rsv_en = 1; rsv_addr = 2;
        tick();
        expect_now(K_ERR, 0); expect_now(K_CNT, 1);
        tick();
        rsv_en = 0;
        expect_now(K_ERR, 1); expect_now(K_CNT, 1);
        tick();
        expect_now(K_ERR, 0);

        // Write and reserve r4 together: new producer wins
        wr_en = 1; wr_addr = 4; wr_data = 16'h00AA; rsv_en = 1; rsv_addr = 4;
        tick();
        wr_en = 0; rsv_en = 0; rd0_addr = 4;
        expect_now(K_D0, 32'h00AA); expect_now(K_B0, 1); expect_now(K_CNT, 2); expect_now(K_ERR, 0);

        // Write r2 and reserve r6 independently
        wr_en = 1; wr_addr = 2; wr_data = 16'h0022; rsv_en = 1; rsv_addr = 6;
        tick();
        wr_en = 0; rsv_en = 0; rd0_addr = 2; rd1_addr = 6;
        expect_now(K_D0, 32'h0022); expect_now(K_B0, 0); expect_now(K_B1, 1); expect_now(K_CNT, 2);

        // Write+reserve to an already-busy r4 still flags the reserve
        wr_en = 1; wr_addr = 4; wr_data = 16'h00BB; rsv_en = 1; rsv_addr = 4;
        tick();
        wr_en = 0; rsv_en = 0; rd0_addr = 4;
        expect_now(K_ERR, 1); expect_now(K_CNT, 2); expect_now(K_D0, 32'h00BB); expect_now(K_B0, 1);

        // Reserve r1, then clr overriding a write to r7
        rsv_en = 1; rsv_addr = 1;
        tick();
        rsv_en = 0;
        expect_now(K_CNT, 3);
        clr = 1; wr_en = 1; wr_addr = 7; wr_data = 16'h7777;
        tick();
        clr = 0; wr_en = 0; rd0_addr = 3; rd1_addr = 7;
        expect_now(K_D0, 0); expect_now(K_D1, 0); expect_now(K_B1, 0);
        expect_now(K_CNT, 0); expect_now(K_ERR, 0);

        // Async reset asserted in the middle of a write
        wr_en = 1; wr_addr = 3; wr_data = 16'h1111; rsv_en = 1; rsv_addr = 3;
        tick();
        wr_en = 0; rsv_en = 0;
        expect_now(K_D0, 32'h1111); expect_now(K_B0, 1); expect_now(K_CNT, 1);
        @(negedge clk);
        #1;
        wr_en = 1; wr_data = 16'h5678;
        rst = 0;
        tick();
        expect_now(K_D0, 0); expect_now(K_B0, 0); expect_now(K_CNT, 0);
        @(negedge clk);
        #1;
        rst = 1; wr_en = 0;
        tick();
        expect_now(K_D0, 0); expect_now(K_CNT, 0);

        // Same-cycle forwarding of write+reserve to r2 (old value without bypass)
        rd0_addr = 2;
        wr_en = 1; wr_addr = 2; wr_data = 16'h0055; rsv_en = 1; rsv_addr = 2;
`ifdef REGFILE_SB_BYPASS_EN
        expect_now(K_D0, 32'h0055); expect_now(K_B0, 1);
`else
        expect_now(K_D0, 0); expect_now(K_B0, 0);
`endif
        tick();
        wr_en = 0; rsv_en = 0;
        expect_now(K_D0, 32'h0055); expect_now(K_B0, 1); expect_now(K_CNT, 1);
        tick();

        // R0_ZERO, NUM_REGS=6 instance
        b_wr_en = 1; b_wr_addr = 0; b_wr_data = 16'hFFFF;
        tick();
        b_wr_addr = 7;
        tick();
        b_wr_en = 0; b_rd0_addr = 0;
        expect_now(K_BD0, 0); expect_now(K_BB0, 0); expect_now(K_BCNT, 0);
        b_rsv_en = 1; b_rsv_addr = 0;
        tick();
        b_rsv_addr = 7;
        expect_now(K_BERR, 0); expect_now(K_BCNT, 0);
        tick();
        b_rsv_en = 0; b_rd0_addr = 7;
        expect_now(K_BERR, 0); expect_now(K_BCNT, 0); expect_now(K_BD0, 0); expect_now(K_BB0, 0);
        b_wr_en = 1; b_wr_addr = 5; b_wr_data = 16'h1357; b_rsv_en = 1; b_rsv_addr = 5;
        tick();
        b_wr_en = 0; b_rd0_addr = 5;
        expect_now(K_BD0, 32'h1357); expect_now(K_BB0, 1); expect_now(K_BCNT, 1); expect_now(K_BERR, 0);
        tick();
        b_rsv_en = 0;
        expect_now(K_BERR, 1); expect_now(K_BCNT, 1);

        for (int i = 0; i < 20 && q.size() > 0; i++) begin
            tick();
        end
        if (q.size() > 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d pending required=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
